// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two
// requesters. Each requester has a valid/ready request channel and a
// valid/ready response channel.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   reqN_valid/ready     request handshake for requester N (N = 0, 1)
//   reqN_fs/a/b          function select and operands for requester N
//   respN_valid/ready    response handshake for requester N
//   respN_f/status/err   captured result, status and illegal-fs flag
//   alu_fs/a/b           registered operands driven to the shared ALU
//   alu_f/status         combinational result returned by the ALU
//   busy                 high whenever the arbiter is not idle
module alu_arbiter #(
    parameter int WIDTH       = 64,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_fs,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_f,
    output logic [3:0]       resp0_status,
    output logic             resp0_err,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_fs,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_f,
    output logic [3:0]       resp1_status,
    output logic             resp1_err,
    output logic [3:0]       alu_fs,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_f,
    input  logic [3:0]       alu_status,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       alu_fs_q, alu_fs_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_f_q [2];
    logic [WIDTH-1:0] resp_f_d [2];
    logic [3:0]       resp_status_q [2];
    logic [3:0]       resp_status_d [2];
    logic [1:0]       resp_err_q, resp_err_d;

    logic             grant;
    logic             req_any;
    logic [3:0]       sel_fs;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             fs_legal;
    logic [1:0]       resp_ready;

    // Under contention the requester that did not win last time is chosen.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req_any    = req0_valid | req1_valid;
    assign sel_fs     = grant ? req1_fs : req0_fs;
    assign sel_a      = grant ? req1_a : req0_a;
    assign sel_b      = grant ? req1_b : req0_b;
    assign resp_ready = {resp1_ready, resp0_ready};

    assign req0_ready = (state_q == IDLE) && !grant && req0_valid;
    assign req1_ready = (state_q == IDLE) && grant && req1_valid;

    always_comb begin
        fs_legal = 1'b0;
        case (sel_fs)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: fs_legal = 1'b1;
            default:                   fs_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        alu_fs_d      = alu_fs_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        resp_valid_d  = resp_valid_q;
        resp_f_d      = resp_f_q;
        resp_status_d = resp_status_q;
        resp_err_d    = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    if (fs_legal) begin
                        alu_fs_d = sel_fs;
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        cnt_d    = CNT_INIT;
                        state_d  = EXEC;
                    end else begin
                        // Illegal op: leave the ALU alone, answer at once.
                        resp_f_d[grant]      = '0;
                        resp_status_d[grant] = '0;
                        resp_err_d[grant]    = 1'b1;
                        resp_valid_d[grant]  = 1'b1;
                        state_d              = RESP;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_f_d[owner_q]      = alu_f;
                    resp_status_d[owner_q] = alu_status;
                    resp_err_d[owner_q]    = 1'b0;
                    resp_valid_d[owner_q]  = 1'b1;
                    state_d                = RESP;
                end
            end
            RESP: begin
                if (resp_ready[owner_q]) begin
                    resp_valid_d[owner_q] = 1'b0;
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            last_grant_q     <= 1'b1;
            owner_q          <= 1'b0;
            cnt_q            <= 4'd0;
            alu_fs_q         <= 4'd0;
            alu_a_q          <= '0;
            alu_b_q          <= '0;
            resp_valid_q     <= 2'b00;
            resp_f_q[0]      <= '0;
            resp_f_q[1]      <= '0;
            resp_status_q[0] <= 4'd0;
            resp_status_q[1] <= 4'd0;
            resp_err_q       <= 2'b00;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            alu_fs_q      <= alu_fs_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            resp_valid_q  <= resp_valid_d;
            resp_f_q      <= resp_f_d;
            resp_status_q <= resp_status_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign alu_fs       = alu_fs_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign resp0_valid  = resp_valid_q[0];
    assign resp1_valid  = resp_valid_q[1];
    assign resp0_f      = resp_f_q[0];
    assign resp1_f      = resp_f_q[1];
    assign resp0_status = resp_status_q[0];
    assign resp1_status = resp_status_q[1];
    assign resp0_err    = resp_err_q[0];
    assign resp1_err    = resp_err_q[1];
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU
// and a scoreboard of expected responses.
module tb_alu_arbiter;

    localparam int W = 64;

    typedef struct {
        int           n;
        logic [W-1:0] f;
        logic [3:0]   st;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_fs, req1_fs;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [W-1:0] resp0_f, resp1_f;
    logic [3:0]   resp0_status, resp1_status;
    logic         resp0_err, resp1_err;
    logic [3:0]   alu_fs, alu_status;
    logic [W-1:0] alu_a, alu_b, alu_f;
    logic         busy;

    logic         e_req0_valid, e_req0_ready, e_req1_valid, e_req1_ready;
    logic [3:0]   e_req0_fs, e_req1_fs;
    logic [W-1:0] e_req0_a, e_req0_b, e_req1_a, e_req1_b;
    logic         e_resp0_valid, e_resp0_ready, e_resp1_valid, e_resp1_ready;
    logic [W-1:0] e_resp0_f, e_resp1_f;
    logic [3:0]   e_resp0_status, e_resp1_status;
    logic         e_resp0_err, e_resp1_err;
    logic [3:0]   e_alu_fs, e_alu_status;
    logic [W-1:0] e_alu_a, e_alu_b, e_alu_f;
    logic         e_busy;

    function automatic logic [W+3:0] alu_model(input logic [3:0] fs,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (fs)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0111: r = b;
            4'b1100: r = ~(a | b);
            default: r = '0;
        endcase
        return {r[W-1], (r == '0), c, v, r};
    endfunction

    always_comb {alu_status, alu_f} = alu_model(alu_fs, alu_a, alu_b);
    always_comb {e_alu_status, e_alu_f} = alu_model(e_alu_fs, e_alu_a, e_alu_b);

    alu_arbiter #(.WIDTH(W), .EXEC_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fs(req0_fs),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_f(resp0_f),
        .resp0_status(resp0_status), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fs(req1_fs),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_f(resp1_f),
        .resp1_status(resp1_status), .resp1_err(resp1_err),
        .alu_fs(alu_fs), .alu_a(alu_a), .alu_b(alu_b),
        .alu_f(alu_f), .alu_status(alu_status), .busy(busy)
    );

    alu_arbiter #(.WIDTH(W), .EXEC_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(e_req0_valid), .req0_ready(e_req0_ready), .req0_fs(e_req0_fs),
        .req0_a(e_req0_a), .req0_b(e_req0_b),
        .resp0_valid(e_resp0_valid), .resp0_ready(e_resp0_ready), .resp0_f(e_resp0_f),
        .resp0_status(e_resp0_status), .resp0_err(e_resp0_err),
        .req1_valid(e_req1_valid), .req1_ready(e_req1_ready), .req1_fs(e_req1_fs),
        .req1_a(e_req1_a), .req1_b(e_req1_b),
        .resp1_valid(e_resp1_valid), .resp1_ready(e_resp1_ready), .resp1_f(e_resp1_f),
        .resp1_status(e_resp1_status), .resp1_err(e_resp1_err),
        .alu_fs(e_alu_fs), .alu_a(e_alu_a), .alu_b(e_alu_b),
        .alu_f(e_alu_f), .alu_status(e_alu_status), .busy(e_busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {63'd0, obs}, {63'd0, exp});
    endtask

    task automatic drive(input int n, input logic [3:0] fs,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (n == 0) begin
            req0_valid = 1'b1; req0_fs = fs; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_fs = fs; req1_a = a; req1_b = b;
        end
    endtask

    task automatic push(input int n);
        exp_t         e;
        logic [3:0]   fs;
        logic [W-1:0] a, b;
        logic [W+3:0] m;
        fs = (n == 0) ? req0_fs : req1_fs;
        a  = (n == 0) ? req0_a : req1_a;
        b  = (n == 0) ? req0_b : req1_b;
        m  = alu_model(fs, a, b);
        e.n = n;
        if (fs inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100}) begin
            e.f = m[W-1:0]; e.st = m[W+3:W]; e.err = 1'b0;
        end else begin
            e.f = '0; e.st = 4'd0; e.err = 1'b1;
        end
        sb.push_back(e);
    endtask

    task automatic release_req(input int n);
        @(posedge clk); #1;
        if (n == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic accept(input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk1({tag, "_accept"}, seen, 1'b1);
        if (seen) push(n);
        release_req(n);
    endtask

    task automatic pop_cmp(input int n, input string tag);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_owner"}, W'(n), W'(e.n));
            chk({tag, "_f"}, (n == 0) ? resp0_f : resp1_f, e.f);
            chk({tag, "_status"}, {60'd0, (n == 0) ? resp0_status : resp1_status},
                {60'd0, e.st});
            chk1({tag, "_err"}, (n == 0) ? resp0_err : resp1_err, e.err);
        end
    endtask

    task automatic get_resp(input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((n == 0) ? resp0_valid : resp1_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk1({tag, "_valid"}, seen, 1'b1);
        if (seen) pop_cmp(n, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W+3:0] m;
        rst = 1'b1;
        req0_valid = 1'b0; req0_fs = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_fs = 4'd0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        e_req0_valid = 1'b0; e_req0_fs = 4'd0; e_req0_a = '0; e_req0_b = '0;
        e_req1_valid = 1'b0; e_req1_fs = 4'd0; e_req1_a = '0; e_req1_b = '0;
        e_resp0_ready = 1'b1; e_resp1_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_v0", resp0_valid, 1'b0);
        chk1("rst_v1", resp1_valid, 1'b0);
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_fs", {60'd0, alu_fs}, '0);
        chk("rst_f0", resp0_f, '0);
        chk1("rst_err0", resp0_err, 1'b0);
        chk1("rst_e_busy", e_busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention straight out of reset: requester 0 first
        drive(0, 4'b0110, 64'd5, 64'd3);
        drive(1, 4'b0001, 64'hF0, 64'h0F);
        @(negedge clk);
        chk1("cont_r0", req0_ready, 1'b1);
        chk1("cont_r1", req1_ready, 1'b0);
        push(0);
        release_req(0);
        @(negedge clk);
        chk1("exec_r1_wait", req1_ready, 1'b0);
        chk1("exec_busy", busy, 1'b1);
        get_resp(0, "sub");
        accept(1, "or");
        get_resp(1, "or");

        // Single ADD with exact latency
        @(posedge clk); #1;
        drive(0, 4'b0010, 64'hFF, 64'hFF);
        @(negedge clk);
        chk1("add_ready", req0_ready, 1'b1);
        chk1("add_idle", busy, 1'b0);
        push(0);
        release_req(0);
        @(negedge clk);
        chk1("add_busy1", busy, 1'b1);
        chk1("add_noresp", resp0_valid, 1'b0);
        chk1("add_ready_lo", req0_ready, 1'b0);
        chk("add_alu_a", alu_a, 64'hFF);
        @(negedge clk);
        chk1("add_v", resp0_valid, 1'b1);
        chk1("add_busy2", busy, 1'b1);
        if (resp0_valid) pop_cmp(0, "add");
        @(negedge clk);
        chk1("add_done_busy", busy, 1'b0);
        chk1("add_done_v", resp0_valid, 1'b0);

        // Second pair after requester 0 won: requester 1 first
        @(posedge clk); #1;
        drive(0, 4'b0000, 64'hAAAA_5555_AAAA_5555, 64'h0F0F_0F0F_0F0F_0F0F);
        drive(1, 4'b0111, 64'h1234, 64'h5678);
        @(negedge clk);
        chk1("pair_r1", req1_ready, 1'b1);
        chk1("pair_r0", req0_ready, 1'b0);
        push(1);
        release_req(1);
        get_resp(1, "passb");
        chk("keep_f0", resp0_f, 64'h1FE);
        chk1("keep_v0", resp0_valid, 1'b0);
        accept(0, "and");
        get_resp(0, "and");

        // Backpressure on requester 1 with requester 0 waiting
        @(posedge clk); #1;
        resp1_ready = 1'b0;
        drive(1, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        m = alu_model(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        accept(1, "bp");
        drive(0, 4'b0001, 64'd3, 64'd4);
        get_resp(1, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("bp_hold_v", resp1_valid, 1'b1);
            chk("bp_hold_f", resp1_f, m[W-1:0]);
            chk("bp_hold_st", {60'd0, resp1_status}, {60'd0, m[W+3:W]});
            chk1("bp_r0_lo", req0_ready, 1'b0);
        end
        @(posedge clk); #1;
        resp1_ready = 1'b1;
        @(negedge clk);
        chk1("bp_rel_r0_lo", req0_ready, 1'b0);
        @(negedge clk);
        chk1("bp_idle", busy, 1'b0);
        chk1("bp_v_clr", resp1_valid, 1'b0);
        chk1("bp_r0_hi", req0_ready, 1'b1);
        if (req0_ready) push(0);
        release_req(0);
        get_resp(0, "or2");

        // Illegal fs leaves the ALU operands alone
        @(posedge clk); #1;
        drive(0, 4'b1010, 64'hDEAD, 64'hBEEF);
        @(negedge clk);
        chk1("ill_ready", req0_ready, 1'b1);
        push(0);
        release_req(0);
        @(negedge clk);
        chk1("ill_v", resp0_valid, 1'b1);
        chk("ill_alu_fs", {60'd0, alu_fs}, 64'd1);
        chk("ill_alu_a", alu_a, 64'd3);
        chk("ill_alu_b", alu_b, 64'd4);
        if (resp0_valid) pop_cmp(0, "ill");
        @(negedge clk);
        chk1("ill_v_clr", resp0_valid, 1'b0);

        // EXEC_CYCLES=4 instance: NOR held four cycles
        @(posedge clk); #1;
        e_req0_valid = 1'b1; e_req0_fs = 4'b1100; e_req0_a = '0; e_req0_b = '0;
        m = alu_model(4'b1100, '0, '0);
        @(negedge clk);
        chk1("nor_ready", e_req0_ready, 1'b1);
        @(posedge clk); #1;
        e_req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nor_alu_fs", {60'd0, e_alu_fs}, 64'd12);
            chk("nor_alu_a", e_alu_a, '0);
            chk1("nor_wait_v", e_resp0_valid, 1'b0);
            chk1("nor_busy", e_busy, 1'b1);
        end
        @(negedge clk);
        chk1("nor_v", e_resp0_valid, 1'b1);
        chk("nor_f", e_resp0_f, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("nor_st", {60'd0, e_resp0_status}, {60'd0, m[W+3:W]});
        chk1("nor_err", e_resp0_err, 1'b0);

        // Reset during EXEC drops the operation
        @(posedge clk); #1;
        drive(0, 4'b0010, 64'd7, 64'd8);
        @(negedge clk);
        chk1("rx_ready", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("rx_busy", busy, 1'b0);
        chk1("rx_v0", resp0_valid, 1'b0);
        chk("rx_alu_a", alu_a, '0);
        @(posedge clk); #1;
        drive(0, 4'b0110, 64'd100, 64'd1);
        drive(1, 4'b0010, 64'd10, 64'd20);
        @(negedge clk);
        chk1("rx_r0", req0_ready, 1'b1);
        chk1("rx_r1", req1_ready, 1'b0);
        push(0);
        release_req(0);
        get_resp(0, "rx_sub");
        accept(1, "rx_add");
        get_resp(1, "rx_add");

        chk("sb_empty", W'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
